line_mem_responder: RTL and testbench

//  Off-chip data-memory responder for the D-cache line interface, serving the memory end of the

---
 rtl/line_mem_responder_pkg.sv | 14 +
 rtl/line_mem_responder_if.sv | 23 ++
 rtl/line_mem_responder_array.sv | 21 ++
 rtl/line_mem_responder.sv | 108 ++++++++++
 tb/tb_line_mem_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/line_mem_responder_pkg.sv
// Shared widths, defaults and FSM encoding for the D-cache line memory responder.
package line_mem_responder_pkg;
  localparam int LINE_W          = 256;
  localparam int ADDR_W          = 32;
  localparam int OFFSET_BITS     = 5;
  localparam int DEFAULT_DEPTH   = 512;
  localparam int DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;
endpackage

// File: rtl/line_mem_responder_if.sv
// Line request bus between the dcache memory port (master) and the responder (slave).
interface line_mem_responder_if;
  import line_mem_responder_pkg::*;

  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              busy_o;
  logic              err_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o, err_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o, err_o
  );
endinterface

// File: rtl/line_mem_responder_array.sv
// Line storage: synchronous write, asynchronous read; contents survive reset.
module line_mem_array
  import line_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    if (we) memory[idx] <= wdata;
  end

  assign rdata = memory[idx];
endmodule

// File: rtl/line_mem_responder.sv
// Memory end of the dcache line protocol: capture, fixed latency, one-cycle ack,
// plus a sticky checker for aborts, unstable requests and out-of-range lines.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic clk_i,
  input  logic rst_i,
  line_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [LINE_W-1:0] cap_data;
  logic              cap_write;
  logic              cap_oob;
  logic              ack;
  logic              busy;
  logic              err;
  logic [LINE_W-1:0] rdata_q;

  logic [ADDR_W-1:0] line_num;
  logic              oob;
  logic              unstable;
  logic              done;
  logic              mem_we;
  logic [LINE_W-1:0] mem_rdata;

  assign line_num = bus.addr_i >> OFFSET_BITS;
  assign oob      = line_num >= ADDR_W'(DEPTH);
  assign unstable = (bus.addr_i != cap_addr) || (bus.write_i != cap_write) ||
                    (cap_write && (bus.data_i != cap_data));
  // Counter reaching zero marks the LATENCY-th edge after capture.
  assign done     = (state == WAIT) && bus.enable_i && (cnt == '0);
  assign mem_we   = done && cap_write && !cap_oob && !rst_i;

  line_mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk   (clk_i),
    .we    (mem_we),
    .idx   (cap_addr[OFFSET_BITS +: IDX_W]),
    .wdata (cap_data),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_write <= 1'b0;
      cap_oob   <= 1'b0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (bus.enable_i) begin
            cap_addr  <= bus.addr_i;
            cap_data  <= bus.data_i;
            cap_write <= bus.write_i;
            cap_oob   <= oob;
            cnt       <= CNT_W'(LATENCY - 1);
            busy      <= 1'b1;
            state     <= WAIT;
            if (oob) err <= 1'b1;
          end
        end
        WAIT: begin
          if (!bus.enable_i) begin
            // Abort takes priority: no commit, no ack.
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (unstable) err <= 1'b1;
            if (cnt == '0) begin
              ack   <= 1'b1;
              state <= ACK;
              if (!cap_write) rdata_q <= cap_oob ? '0 : mem_rdata;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        ACK: begin
          ack   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack_o  = ack;
  assign bus.data_o = rdata_q;
  assign bus.busy_o = busy;
  assign bus.err_o  = err;
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: latency, commit timing, abort, range, reset, back-to-back.
module tb_line_mem_responder;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n;
  int   acks;
  logic [255:0] sb [$];

  localparam logic [255:0] P0   = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] ECFA = 256'hECFA_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_1357_9BDF_2468_ACE0_1111_2222_ECFA;
  localparam logic [255:0] WQ   = 256'h5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0_0000_FFFF_C3C3_3C3C_8001_1008_7777_BEEF_CAFE;

  line_mem_responder_if bus_a ();
  line_mem_responder_if bus_b ();

  line_mem_responder #(.DEPTH(512), .LATENCY(10)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  line_mem_responder #(.DEPTH(512), .LATENCY(2))  dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  always #5 clk = ~clk;

  function automatic logic [255:0] pre(input int i);
    return {8{32'hA500_0000 | 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag, input logic [255:0] obs);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 256'd1, 256'd0);
    else chk(tag, obs, sb.pop_front());
  endtask

  task automatic req_a(input logic [31:0] a, input logic w, input logic [255:0] d);
    bus_a.addr_i   = a;
    bus_a.write_i  = w;
    bus_a.data_i   = d;
    bus_a.enable_i = 1'b1;
    tick();
  endtask

  task automatic wait_ack_a(output int cnt);
    cnt = 0;
    while (bus_a.ack_o !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_ack_b(output int cnt);
    cnt = 0;
    while (bus_b.ack_o !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  task automatic release_a();
    bus_a.enable_i = 1'b0;
    bus_a.write_i  = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    dut_a.u_mem.memory[0] = P0;
    dut_b.u_mem.memory[0] = P0;
    for (int i = 1; i < 32; i++) begin
      dut_a.u_mem.memory[i] = pre(i);
      dut_b.u_mem.memory[i] = pre(i);
    end
    rst = 1'b1;
    bus_a.addr_i = '0; bus_a.data_i = '0; bus_a.enable_i = 1'b0; bus_a.write_i = 1'b0;
    bus_b.addr_i = '0; bus_b.data_i = '0; bus_b.enable_i = 1'b0; bus_b.write_i = 1'b0;
    tick();
    tick();
    chk("rst_ack",  256'(bus_a.ack_o),  256'd0);
    chk("rst_data", bus_a.data_o,       256'd0);
    chk("rst_busy", 256'(bus_a.busy_o), 256'd0);
    chk("rst_err",  256'(bus_a.err_o),  256'd0);
    rst = 1'b0;

    // Read of preloaded line 0
    sb.push_back(P0);
    req_a(32'h0, 1'b0, '0);
    chk("t1_busy", 256'(bus_a.busy_o), 256'd1);
    wait_ack_a(n);
    chk("t1_lat", 256'(n), 256'd10);
    check_sb("t1_data", bus_a.data_o);
    chk("t1_err", 256'(bus_a.err_o), 256'd0);
    release_a();
    chk("t1_pulse", 256'(bus_a.ack_o),  256'd0);
    chk("t1_idle",  256'(bus_a.busy_o), 256'd0);
    chk("t1_hold",  bus_a.data_o, P0);

    // Write 0x40 then read it back; commit lands on the ack-rise edge
    req_a(32'h40, 1'b1, ECFA);
    repeat (9) tick();
    chk("t2_mem_pre", dut_a.u_mem.memory[2], pre(2));
    chk("t2_noack",   256'(bus_a.ack_o), 256'd0);
    wait_ack_a(n);
    chk("t2_lat_last", 256'(n), 256'd1);
    chk("t2_mem_post", dut_a.u_mem.memory[2], ECFA);
    release_a();
    sb.push_back(ECFA);
    req_a(32'h40, 1'b0, '0);
    wait_ack_a(n);
    chk("t2_rd_lat", 256'(n), 256'd10);
    check_sb("t2_rd_data", bus_a.data_o);
    chk("t2_err", 256'(bus_a.err_o), 256'd0);
    release_a();

    // Abort a write to 0x200 at edge 4
    req_a(32'h200, 1'b1, WQ);
    repeat (3) tick();
    bus_a.enable_i = 1'b0;
    tick();
    chk("t3_busy", 256'(bus_a.busy_o), 256'd0);
    acks = 0;
    repeat (20) begin
      tick();
      if (bus_a.ack_o === 1'b1) acks++;
    end
    chk("t3_noack", 256'(acks), 256'd0);
    chk("t3_mem",   dut_a.u_mem.memory[16], pre(16));
    chk("t3_err",   256'(bus_a.err_o), 256'd1);
    do_reset();
    chk("t3_err_clr", 256'(bus_a.err_o), 256'd0);

    // Out-of-range read and write at 0x4000 (aliases line 0 if not guarded)
    sb.push_back(P0);
    req_a(32'h0, 1'b0, '0);
    wait_ack_a(n);
    check_sb("t4_pre_data", bus_a.data_o);
    release_a();
    sb.push_back('0);
    req_a(32'h4000, 1'b0, '0);
    wait_ack_a(n);
    chk("t4_lat", 256'(n), 256'd10);
    check_sb("t4_data", bus_a.data_o);
    chk("t4_err", 256'(bus_a.err_o), 256'd1);
    release_a();
    req_a(32'h4000, 1'b1, WQ);
    wait_ack_a(n);
    chk("t4_wr_lat", 256'(n), 256'd10);
    release_a();
    chk("t4_wr_drop", dut_a.u_mem.memory[0], P0);

    // Request changes mid-flight: flagged, captured values still used
    do_reset();
    req_a(32'h80, 1'b1, WQ);
    tick();
    bus_a.addr_i = 32'hA0;
    tick();
    bus_a.addr_i = 32'h80;
    chk("ts_err", 256'(bus_a.err_o), 256'd1);
    wait_ack_a(n);
    chk("ts_lat", 256'(n), 256'd8);
    chk("ts_mem",   dut_a.u_mem.memory[4], WQ);
    chk("ts_other", dut_a.u_mem.memory[5], pre(5));
    release_a();

    // Reset mid-WAIT of a write to 0x60
    do_reset();
    sb.push_back(P0);
    req_a(32'h0, 1'b0, '0);
    wait_ack_a(n);
    check_sb("t5_pre_data", bus_a.data_o);
    release_a();
    req_a(32'h60, 1'b1, WQ);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_a.enable_i = 1'b0;
    chk("t5_ack",  256'(bus_a.ack_o),  256'd0);
    chk("t5_data", bus_a.data_o,       256'd0);
    chk("t5_busy", 256'(bus_a.busy_o), 256'd0);
    chk("t5_err",  256'(bus_a.err_o),  256'd0);
    acks = 0;
    repeat (15) begin
      tick();
      if (bus_a.ack_o === 1'b1) acks++;
    end
    chk("t5_noack", 256'(acks), 256'd0);
    chk("t5_mem",   dut_a.u_mem.memory[3], pre(3));
    sb.push_back(pre(3));
    req_a(32'h60, 1'b0, '0);
    wait_ack_a(n);
    chk("t5_rd_lat", 256'(n), 256'd10);
    check_sb("t5_rd_data", bus_a.data_o);
    release_a();

    // Back-to-back on the LATENCY=2 instance with enable held high
    sb.push_back(pre(1));
    bus_b.addr_i   = 32'h20;
    bus_b.write_i  = 1'b0;
    bus_b.enable_i = 1'b1;
    tick();
    wait_ack_b(n);
    chk("t6_lat1", 256'(n), 256'd2);
    check_sb("t6_data1", bus_b.data_o);
    bus_b.addr_i = 32'h0;
    sb.push_back(P0);
    tick();
    chk("t6_ack_off", 256'(bus_b.ack_o),  256'd0);
    chk("t6_idle",    256'(bus_b.busy_o), 256'd0);
    tick();
    chk("t6_capture", 256'(bus_b.busy_o), 256'd1);
    wait_ack_b(n);
    chk("t6_lat2", 256'(n), 256'd2);
    check_sb("t6_data2", bus_b.data_o);
    chk("t6_err", 256'(bus_b.err_o), 256'd0);
    bus_b.enable_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
